// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared widths, lane slices, FSM encoding and round-constant helper
package ascon_pkg;

  localparam int ROUNDS_MAX = 12;
  localparam int STATE_W    = 320;
  localparam int LANE_W     = 64;

  localparam int X0_LSB = 256;
  localparam int X1_LSB = 192;
  localparam int X2_LSB = 128;
  localparam int X3_LSB = 64;
  localparam int X4_LSB = 0;

  // Sequencer states: IDLE -> RUN -> DONE -> IDLE.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Round constant for round index i of the 12-round schedule: {15-i, i}.
  function automatic logic [7:0] rc(input logic [3:0] i);
    rc = {4'd15 - i, i};
  endfunction

endpackage

// File: rtl/ascon_p.sv
// rtl/ascon_p.sv - one combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion
module ascon_p (
  input  logic [319:0] state_in,
  input  logic [7:0]   rcon,
  output logic [319:0] state_out
);
  import ascon_pkg::*;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    ror = (x >> n) | (x << (LANE_W - n));
  endfunction

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] d0, d1, d2, d3, d4;
  logic [63:0] e0, e1, e2, e3, e4;

  always_comb begin
    a0 = state_in[X0_LSB +: LANE_W];
    a1 = state_in[X1_LSB +: LANE_W];
    a2 = state_in[X2_LSB +: LANE_W] ^ {56'd0, rcon};
    a3 = state_in[X3_LSB +: LANE_W];
    a4 = state_in[X4_LSB +: LANE_W];

    b0 = a0 ^ a4;
    b1 = a1;
    b2 = a2 ^ a1;
    b3 = a3;
    b4 = a4 ^ a3;

    // Bitsliced chi core of the S-box: x_i ^= ~x_{i+1} & x_{i+2}.
    c0 = b0 ^ (~b1 & b2);
    c1 = b1 ^ (~b2 & b3);
    c2 = b2 ^ (~b3 & b4);
    c3 = b3 ^ (~b4 & b0);
    c4 = b4 ^ (~b0 & b1);

    d0 = c0 ^ c4;
    d1 = c1 ^ c0;
    d2 = ~c2;
    d3 = c3 ^ c2;
    d4 = c4;

    e0 = d0 ^ ror(d0, 19) ^ ror(d0, 28);
    e1 = d1 ^ ror(d1, 61) ^ ror(d1, 39);
    e2 = d2 ^ ror(d2, 1)  ^ ror(d2, 6);
    e3 = d3 ^ ror(d3, 10) ^ ror(d3, 17);
    e4 = d4 ^ ror(d4, 7)  ^ ror(d4, 41);
  end

  assign state_out = {e0, e1, e2, e3, e4};

endmodule

// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - sequential Ascon permutation, one round per cycle
// ASCON_UNROLL2_EN: two chained rounds per RUN cycle.
module ascon_perm_seq #(
  parameter int ROUNDS_MAX = ascon_pkg::ROUNDS_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   rounds,
  input  logic [319:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] state_out
);
  import ascon_pkg::*;

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   rcnt_q, rcnt_d;
  logic [319:0] state_q, state_d;

  logic [3:0]   rounds_eff;
  logic [7:0]   rc0;
  logic [319:0] round1;

  always_comb rounds_eff = (rounds > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds;
  always_comb rc0 = rc(rcnt_q);

  ascon_p u_round0 (
    .state_in  (state_q),
    .rcon      (rc0),
    .state_out (round1)
  );

`ifdef ASCON_UNROLL2_EN
  logic [7:0]   rc1;
  logic [319:0] round2;

  always_comb rc1 = rc(rcnt_q + 4'd1);

  ascon_p u_round1 (
    .state_in  (round1),
    .rcon      (rc1),
    .state_out (round2)
  );
`endif

  always_comb begin
    fsm_d   = fsm_q;
    rcnt_d  = rcnt_q;
    state_d = state_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          // The schedule always ends at index 11, so shorter calls start later.
          state_d = state_in;
          rcnt_d  = 4'd12 - rounds_eff;
          fsm_d   = (rounds_eff == 4'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
`ifdef ASCON_UNROLL2_EN
        if (rcnt_q == 4'd11) begin
          state_d = round1;
          rcnt_d  = rcnt_q + 4'd1;
          fsm_d   = ST_DONE;
        end else begin
          state_d = round2;
          rcnt_d  = rcnt_q + 4'd2;
          if (rcnt_q == 4'd10) fsm_d = ST_DONE;
        end
`else
        state_d = round1;
        rcnt_d  = rcnt_q + 4'd1;
        if (rcnt_q == 4'd11) fsm_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      rcnt_q  <= 4'd0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
    end
  end

  // Gating with rst_n keeps in_ready low through the reset cycle itself.
  assign in_ready  = rst_n && (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign state_out = state_q;

endmodule

// File: tb/tb_ascon_perm_seq.sv
// tb/tb_ascon_perm_seq.sv - directed scoreboard bench for ascon_perm_seq (both ASCON_UNROLL2_EN builds)
module tb_ascon_perm_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   rounds = 4'd0;
  logic [319:0] state_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] state_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [319:0] exp_q[$];
  int           lat_q[$];

`ifdef ASCON_UNROLL2_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  always #5 clk = ~clk;

  ascon_perm_seq #(.ROUNDS_MAX(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rounds    (rounds),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] w;
    w = {v, v} >> n;
    return w[63:0];
  endfunction

  function automatic logic [7:0] rc_m(input int i);
    return 8'(((15 - i) << 4) | i);
  endfunction

  function automatic int clamp(input logic [3:0] r);
    return (r > 4'd12) ? 12 : int'(r);
  endfunction

  function automatic logic [319:0] m_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x[5];
    logic [63:0] t[5];
    logic [319:0] r;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2] ^= {56'd0, c};
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
    x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
    x[2] ^= rotr(x[2], 1)  ^ rotr(x[2], 6);
    x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
    x[4] ^= rotr(x[4], 7)  ^ rotr(x[4], 41);
    for (int i = 0; i < 5; i++) r[319 - 64*i -: 64] = x[i];
    return r;
  endfunction

  function automatic logic [319:0] m_perm(input logic [319:0] s, input logic [3:0] r);
    logic [319:0] v;
    v = s;
    for (int i = 12 - clamp(r); i < 12; i++) v = m_round(v, rc_m(i));
    return v;
  endfunction

  function automatic int exp_lat(input logic [3:0] r);
    int n;
    n = clamp(r);
    return (STEP == 2) ? (n + 1) / 2 + 1 : n + 1;
  endfunction

  function automatic logic [319:0] rnd320();
    return {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] r, input logic [319:0] s, input int bp);
    int cyc;
    int base;
    int e_lat;
    logic [319:0] e_state;
    @(negedge clk);
    chk("in_ready_idle", {319'd0, in_ready}, 320'd1);
    in_valid = 1'b1;
    rounds   = r;
    state_in = s;
    exp_q.push_back(m_perm(s, r));
    lat_q.push_back(exp_lat(r));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rounds   = 4'($urandom);
    state_in = rnd320();
    cyc  = 1;
    base = 12 - clamp(r);
    while (out_valid !== 1'b1 && cyc < 40) begin
      chk("in_ready_busy", {319'd0, in_ready}, 320'd0);
      chk("round_const", {312'd0, dut.u_round0.rcon}, {312'd0, rc_m(base + (cyc - 1) * STEP)});
      in_valid = cyc[0];
      state_in = rnd320();
      @(negedge clk);
      cyc++;
    end
    e_state = exp_q.pop_front();
    e_lat   = lat_q.pop_front();
    chk("latency", 320'(cyc), 320'(e_lat));
    chk("out_valid", {319'd0, out_valid}, 320'd1);
    chk("state_out", state_out, e_state);
    for (int k = 0; k < bp; k++) begin
      in_valid = 1'b1;
      rounds   = 4'd1;
      state_in = rnd320();
      @(negedge clk);
      chk("bp_out_valid", {319'd0, out_valid}, 320'd1);
      chk("bp_in_ready", {319'd0, in_ready}, 320'd0);
      chk("bp_state", state_out, e_state);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_out_valid", {319'd0, out_valid}, 320'd0);
    chk("release_in_ready", {319'd0, in_ready}, 320'd1);
    chk("idle_state", state_out, e_state);
  endtask

  initial begin
    logic [319:0] iv;
    iv = {64'h80400c0600000000, 256'd0};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {319'd0, in_ready}, 320'd0);
    chk("rst_out_valid", {319'd0, out_valid}, 320'd0);
    chk("rst_state", state_out, 320'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {319'd0, in_ready}, 320'd1);

    run_op(4'd1,  320'd0,   0);
    run_op(4'd12, iv,       0);
    run_op(4'd6,  rnd320(), 0);
    run_op(4'd15, iv,       0);
    run_op(4'd0,  rnd320(), 0);
    run_op(4'd8,  rnd320(), 5);
    run_op(4'd7,  rnd320(), 2);
    run_op(4'd12, rnd320(), 0);

    // Abort a 12-round call in its fourth RUN cycle.
    @(negedge clk);
    in_valid = 1'b1;
    rounds   = 4'd12;
    state_in = rnd320();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", {319'd0, out_valid}, 320'd0);
    chk("abort_in_ready", {319'd0, in_ready}, 320'd0);
    chk("abort_state", state_out, 320'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", {319'd0, in_ready}, 320'd1);
    chk("abort_idle_valid", {319'd0, out_valid}, 320'd0);
    chk("abort_idle_state", state_out, 320'd0);

    run_op(4'd12, rnd320(), 0);
    run_op(4'd1,  rnd320(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_perm_seq.md
ASCON_PERM_SEQ -- requirements
Module: ascon_perm_seq

Interface
REQ-001 SHALL have parameter ROUNDS_MAX, default 12, meaning the maximum rounds per permutation call.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request carries valid state_in and rounds.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port rounds  input  4  rounds to apply: 6 for p^b, 8 for p^b128a, 12 for p^a.
REQ-007 SHALL have port state_in  input  320  {x0,x1,x2,x3,x4}; x0 in bits 319:256.
REQ-008 SHALL have port out_valid  output  1  state_out holds the permuted result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port state_out  output  320  permuted state, same packing as state_in.

Function
REQ-011 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-012 SHALL accept a request when in_valid&&in_ready, registering state_in and rcnt=12-rounds, and SHALL sample rounds only at acceptance.
REQ-013 SHALL clamp rounds>12 to 12; rounds=0 SHALL go IDLE->DONE with state unchanged.
REQ-014 SHALL, in each RUN cycle, set state<=round(state, c_r(rcnt)) and rcnt<=rcnt+1, then enter DONE after the cycle in which rcnt==11.
REQ-015 SHALL compute the round constant as c_r(i) = {4'(15-i), 4'(i)}, giving 0xf0 for i=0 and 0x4b for i=11, zero-extended into x2.
REQ-016 SHALL have a latency from the accept edge to out_valid of rounds+1 cycles; rounds=12 gives 13.
REQ-017 SHALL keep state_out equal to the state register at all times, and state_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 SHALL return DONE to IDLE on out_valid&&out_ready, so in_ready rises the next cycle; there is no same-cycle accept-while-done.
REQ-019 SHALL ignore in_valid outside IDLE and SHALL not sample inputs while in RUN.

Reset
REQ-020 SHALL, while rst_n=0 at an edge, force FSM=IDLE, rcnt=0, state=0, out_valid=0.
REQ-021 SHALL drive in_ready=0 during the reset cycle and 1 on the first cycle after reset is released.
REQ-022 SHALL, on reset in RUN or DONE, abort the operation with no out_valid pulse and discard any partial state.

Configuration
REQ-023 SHALL, with ASCON_UNROLL2_EN defined, chain two round instances per RUN cycle with constants c_r(rcnt) and c_r(rcnt+1), incrementing rcnt by 2.
REQ-024 SHALL, with ASCON_UNROLL2_EN, apply only the first round in the last RUN cycle of an odd count; latency SHALL be ceil(rounds/2)+1 and results SHALL be bit-identical to the non-unrolled build.
REQ-025 SHALL, without ASCON_UNROLL2_EN, use one round instance per cycle, as in REQ-014 and REQ-016.

Structure
REQ-026 SHALL take ROUNDS_MAX, the 320-bit state width, the state field slice constants, the FSM state enum and the function rc(i) from a shared package ascon_pkg.
REQ-027 SHALL instantiate the team's single-round combinational module ascon_p as its only sub-module, once or twice per REQ-023.

Verification
REQ-028 SHALL verify single round: state_in=0, rounds=1 -> out_valid after 2 cycles; state_out equals golden ascon_p(0, c_r=0x4b).
REQ-029 SHALL verify full p^a: state_in = IV 0x80400c0600000000 with key and nonce zero, rounds=12 -> out_valid at cycle 13; result matches C reference model; constants observed 0xf0..0x4b.
REQ-030 SHALL verify p^b and clamping: rounds=6 -> first constant 0x96, latency 7; rounds=15 -> identical to rounds=12.
REQ-031 SHALL verify backpressure: out_ready held 0 for 5 cycles after out_valid -> state_out stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-032 SHALL verify reset mid-RUN: rst_n=0 at round 4 of 12 -> next cycle IDLE, out_valid=0, state_out=0; a new request then completes correctly.
REQ-033 SHALL verify the unrolled build: with ASCON_UNROLL2_EN, rounds=7 and 12 -> latencies 5 and 7; outputs identical to the non-unrolled build.
